noc_port_arbiter: RTL and testbench
===================================

Name: noc_port_arbiter

Overview:
- Clocked output-port arbiter for one direction of a mesh router. Five requesters (left, right, up, down, PE) each present a 33-bit flit; one shared output link.
- Fair round-robin grant, one-entry registered output stage, stall watchdog.
- Instantiated once per router output port.
- Flits are single-flit packets, so there is no wormhole lock.

Parameters:
- N_IN, 5, number of requesters; index order 0=left, 1=right, 2=up, 3=down, 4=pe.
- FLIT_W, 33, flit width in bits.
- TIMEOUT, 1024, consecutive stalled cycles before stall_err sets; legal range 1..65535.
- CNT_W, $clog2(TIMEOUT+1), width of the stall counter (derived).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  N_IN  per-requester flit valid.
- in_data  in  N_IN*FLIT_W  packed flits; requester i occupies bits [i*FLIT_W +: FLIT_W].
- in_ready  out  N_IN  per-requester accept, one-hot or zero.
- out_valid  out  1  output register holds a flit.
- out_data  out  FLIT_W  output flit.
- out_ready  in  1  downstream accepts out_data this cycle.
- last_grant  out  3  index of the most recently granted requester.
- stall_err  out  1  sticky watchdog error.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Handshake:
  - valid/ready; a transfer occurs on a rising edge where valid & ready.
  - Requesters hold valid and data stable until they are accepted.
  - Downstream may drive out_ready freely.
- Reset values at the first edge with reset=1:
  - out_valid=0, out_data=0, last_grant=N_IN-1, stall counter=0, stall_err=0.
  - in_ready is forced to 0 combinationally while reset is high.
  - Reset mid-transfer discards any held flit. No partial output.
- States, derived from out_valid:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- slot_free = !out_valid | out_ready.
- Arbitration (combinational):
  - Search order is last_grant+1, last_grant+2, … modulo N_IN. The first i with in_valid[i]=1 is g.
  - in_ready[g] = slot_free & !reset. All other in_ready bits are 0.
  - in_ready may depend on in_valid. Requesters must not make valid depend on ready.
- Edge update:
  - If a grant occurred: out_data<=in_data[g], out_valid<=1, last_grant<=g.
  - Else if out_valid & out_ready: out_valid<=0, and out_data holds its old value.
  - Else: hold.
- Latency and throughput:
  - Input to output latency is 1 cycle.
  - Sustained throughput is 1 flit per cycle with out_ready held high. FULL→FULL via a simultaneous drain and refill is allowed.
- Fairness: with all N_IN requesters continuously valid, the grant sequence is strictly cyclic. Worst-case wait is N_IN-1 grants.
- last_grant is unchanged when no grant occurs, so priority rotates only on an actual transfer.
- Watchdog:
  - The stall counter increments each cycle out_valid & !out_ready, saturating at TIMEOUT. It clears to 0 on any output transfer or when out_valid=0.
  - stall_err<=1 on the edge where the counter reaches TIMEOUT. It stays set until reset; later transfers do not clear it.
  - The arbiter keeps operating after stall_err is set.
- Stability: while FULL and !out_ready, out_data and out_valid must not change.
- Out of range: in_valid bits above N_IN-1 do not exist; last_grant never exceeds N_IN-1.

Decomposition:
- Shared package noc_pkg holds:
  - FLIT_W=33, N_PORTS=5.
  - Port index constants PORT_LEFT=0, PORT_RIGHT=1, PORT_UP=2, PORT_DOWN=3, PORT_PE=4.
  - typedef flit_t = logic [FLIT_W-1:0].
  - Destination field slices DEST_X=[32:31], DEST_Y=[30:29], matching the router's 2-bit X/Y addressing.
- One natural sub-module, rr_picker:
  - Combinational; inputs are the request vector and the last grant.
  - Outputs are the one-hot grant and the encoded index.
  - Reusable by the router input-side allocator.

Test Plan:
- Single requester: in_valid=5'b00100, data 33'h0_1234_5678, out_ready=1 → in_ready=5'b00100 that cycle. Next cycle out_valid=1, out_data=33'h0_1234_5678, last_grant=2.
- All five valid continuously after reset, out_ready=1 → grants in order 0,1,2,3,4,0,… with one output per cycle and no gaps.
- Backpressure: out_ready=0 for 10 cycles while FULL → in_ready=0, and out_data/out_valid are stable. Release out_ready → drain and the next grant happen the same cycle.
- Watchdog with TIMEOUT=8: hold out_ready=0 while FULL → stall_err rises after 8 stalled cycles. A later transfer leaves stall_err=1; only reset clears it.
- Reset mid-operation: assert reset for one cycle while FULL with last_grant=3 → next cycle out_valid=0, last_grant=4, stall_err=0, and in_ready=0 during reset. Requester 0 is served first afterwards.
- Skip fairness: requesters 1 and 3 valid, last_grant=1 → grant 3, then 1, then 3. Grants alternate and requesters 0, 2, 4 are never granted.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit format, router port indices and the
// output-stage state encoding used by the per-port arbiter.
package noc_pkg;

  localparam int unsigned FLIT_W  = 33;
  localparam int unsigned N_PORTS = 5;

  // Requester / port index order shared by all router blocks
  localparam int unsigned PORT_LEFT  = 0;
  localparam int unsigned PORT_RIGHT = 1;
  localparam int unsigned PORT_UP    = 2;
  localparam int unsigned PORT_DOWN  = 3;
  localparam int unsigned PORT_PE    = 4;

  typedef logic [FLIT_W-1:0] flit_t;

  // Destination coordinate fields inside a flit (2-bit X/Y mesh addressing)
  localparam int unsigned DEST_X_HI = 32;
  localparam int unsigned DEST_X_LO = 31;
  localparam int unsigned DEST_Y_HI = 30;
  localparam int unsigned DEST_Y_LO = 29;

  // One-entry output stage; encoding chosen so FULL decodes directly as valid
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
// Searches req_i starting just after last_i (wrapping modulo N) and returns
// the first requester found.
//   req_i     : request vector
//   last_i    : index of the previous winner
//   gnt_oh_c  : one-hot grant (zero when nothing requests)
//   gnt_idx_c : encoded grant index
//   gnt_vld_c : some requester was picked
module rr_picker
  import noc_pkg::*;
#(
  parameter int unsigned N     = 5,
  parameter int unsigned IDX_W = 3
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N-1:0]     gnt_oh_c,
  output logic [IDX_W-1:0] gnt_idx_c,
  output logic             gnt_vld_c
);

  localparam int unsigned SEL_W = $clog2(N);

  // First requester at offset 1..N from the previous winner; offset N wraps
  // back to the previous winner itself, so it is served only when alone.
  always_comb begin
    int unsigned k;
    gnt_oh_c  = '0;
    gnt_idx_c = '0;
    gnt_vld_c = 1'b0;
    k         = 0;
    for (int unsigned off = 1; off <= N; off++) begin
      k = (32'(last_i) + off) % N;
      if (!gnt_vld_c && req_i[SEL_W'(k)]) begin
        gnt_vld_c             = 1'b1;
        gnt_idx_c             = IDX_W'(k);
        gnt_oh_c[SEL_W'(k)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_port_arbiter.sv
// Output-port arbiter for one direction of a mesh router.
// Round-robin selection among N_IN requesters into a one-entry registered
// output stage, with a sticky stall watchdog on the output link.
//   clk, reset            : clock, synchronous active-high reset
//   in_valid/in_data      : per-requester flits, requester i at [i*FLIT_W +: FLIT_W]
//   in_ready              : combinational accept, one-hot or zero
//   out_valid/out_data    : registered output flit
//   out_ready             : downstream accept
//   last_grant            : most recently granted requester
//   stall_err             : sticky, set after TIMEOUT consecutive stalled cycles
module noc_port_arbiter #(
  parameter int unsigned N_IN    = noc_pkg::N_PORTS,
  parameter int unsigned FLIT_W  = noc_pkg::FLIT_W,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_IN-1:0]          in_valid,
  input  logic [N_IN*FLIT_W-1:0]   in_data,
  output logic [N_IN-1:0]          in_ready,
  output logic                     out_valid,
  output logic [FLIT_W-1:0]        out_data,
  input  logic                     out_ready,
  output logic [2:0]               last_grant,
  output logic                     stall_err
);

  import noc_pkg::*;

  localparam int unsigned IDX_W = 3;

  out_state_e          state_q, state_d;
  logic [FLIT_W-1:0]   out_data_q, out_data_d;
  logic [IDX_W-1:0]    last_grant_q, last_grant_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic                stall_err_q, stall_err_d;

  logic [N_IN-1:0]     gnt_oh_c;
  logic [IDX_W-1:0]    gnt_idx_c;
  logic                gnt_vld_c;
  logic                slot_free_c;
  logic                grant_c;
  logic                stall_c;

  logic [FLIT_W-1:0]   in_flit [N_IN];

  // Unpack the flit bus so the winner can be selected by index
  for (genvar i = 0; i < N_IN; i++) begin : g_unpack
    assign in_flit[i] = in_data[i*FLIT_W +: FLIT_W];
  end

  rr_picker #(
    .N     (N_IN),
    .IDX_W (IDX_W)
  ) u_rr_picker (
    .req_i     (in_valid),
    .last_i    (last_grant_q),
    .gnt_oh_c  (gnt_oh_c),
    .gnt_idx_c (gnt_idx_c),
    .gnt_vld_c (gnt_vld_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_EMPTY;
      out_data_q   <= '0;
      last_grant_q <= IDX_W'(N_IN - 1);
      stall_cnt_q  <= '0;
      stall_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_data_q   <= out_data_d;
      last_grant_q <= last_grant_d;
      stall_cnt_q  <= stall_cnt_d;
      stall_err_q  <= stall_err_d;
    end
  end

  // Grant, accept and output-stage next state; a drain and refill may
  // happen on the same edge, keeping the stage FULL.
  always_comb begin
    state_d      = state_q;
    out_data_d   = out_data_q;
    last_grant_d = last_grant_q;
    slot_free_c  = (state_q == ST_EMPTY) || out_ready;
    grant_c      = gnt_vld_c && slot_free_c && !reset;
    in_ready     = grant_c ? gnt_oh_c : '0;

    if (grant_c) begin
      state_d      = ST_FULL;
      out_data_d   = in_flit[gnt_idx_c];
      last_grant_d = gnt_idx_c;
    end else if ((state_q == ST_FULL) && out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  // Watchdog: count consecutive held-but-not-accepted cycles, saturating
  always_comb begin
    stall_cnt_d = '0;
    stall_c     = (state_q == ST_FULL) && !out_ready;
    if (stall_c) begin
      stall_cnt_d = (stall_cnt_q == CNT_W'(TIMEOUT)) ? stall_cnt_q
                                                     : stall_cnt_q + CNT_W'(1);
    end
    stall_err_d = stall_err_q || (stall_cnt_d == CNT_W'(TIMEOUT));
  end

  assign out_valid  = (state_q == ST_FULL);
  assign out_data   = out_data_q;
  assign last_grant = last_grant_q;
  assign stall_err  = stall_err_q;

endmodule

// File: tb/tb_noc_port_arbiter.sv
// Self-checking bench for noc_port_arbiter (TIMEOUT reduced to 8).
// Directed scenarios followed by a randomized run, all compared against a
// transaction-level reference model of the output port.
module tb_noc_port_arbiter;

  localparam int unsigned N  = 5;
  localparam int unsigned W  = 33;
  localparam int unsigned TO = 8;
  localparam int unsigned DW = N * W;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   in_valid;
  logic [DW-1:0]  in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_ready;
  logic [2:0]     last_grant;
  logic           stall_err;

  noc_port_arbiter #(
    .N_IN    (N),
    .FLIT_W  (W),
    .TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .last_grant (last_grant),
    .stall_err  (stall_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Requester side: pending flags and the flit each one currently offers
  logic [N-1:0] req_v;
  logic [W-1:0] flit [N];

  // Reference model of the output port
  logic         m_valid;
  logic [W-1:0] m_data;
  int           m_last;
  int           m_cnt;
  logic         m_err;

  logic [N-1:0] obs_ready;
  int           acc;
  logic [W-1:0] snap;
  int           seq [3];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_flit();
    return {1'($urandom()), $urandom()};
  endfunction

  // Round-robin rule: first pending requester after the last winner, wrapping
  function automatic int pick(input logic [N-1:0] v, input int last);
    logic [N-1:0] t;
    for (int off = 1; off <= N; off++) begin
      t = v >> ((last + off) % N);
      if (t[0]) return (last + off) % N;
    end
    return -1;
  endfunction

  // One clock: drive at negedge, check in_ready, advance model at posedge,
  // then check the registered outputs.
  task automatic cycle(input logic rdy, input logic rst);
    int g;
    logic slot;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    reset     = rst;
    out_ready = rdy;
    in_valid  = req_v;
    in_data   = '0;
    for (int i = 0; i < N; i++) in_data = in_data | (DW'(flit[i]) << (i * W));
    #1;
    g       = pick(req_v, m_last);
    slot    = !m_valid || rdy;
    exp_rdy = (!rst && slot && g >= 0) ? (N'(1) << g) : '0;
    obs_ready = in_ready;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    acc = (!rst && slot) ? g : -1;
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0; m_data = '0; m_last = N - 1; m_cnt = 0; m_err = 1'b0;
    end else begin
      if (m_valid && !rdy) m_cnt = (m_cnt < TO) ? m_cnt + 1 : m_cnt;
      else                 m_cnt = 0;
      if (m_cnt == TO) m_err = 1'b1;
      if (acc >= 0) begin
        m_valid = 1'b1; m_data = flit[acc]; m_last = acc;
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
    end
    #1;
    chk("out_valid",  64'(out_valid),  64'(m_valid));
    chk("out_data",   64'(out_data),   64'(m_data));
    chk("last_grant", 64'(last_grant), 64'(m_last));
    chk("stall_err",  64'(stall_err),  64'(m_err));
  endtask

  // After an accept the winner offers a fresh flit, optionally staying valid
  task automatic refill(input bit keep);
    if (acc >= 0) begin
      flit[acc] = rnd_flit();
      if (!keep) req_v = req_v & ~(N'(1) << acc);
    end
  endtask

  initial begin
    reset = 1'b1; out_ready = 1'b0; in_valid = '0; in_data = '0; req_v = '0;
    for (int i = 0; i < N; i++) flit[i] = rnd_flit();
    m_valid = 1'b0; m_data = '0; m_last = N - 1; m_cnt = 0; m_err = 1'b0; acc = -1;

    // Reset state
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    chk("rst_last_grant", 64'(last_grant), 64'd4);
    chk("rst_out_valid",  64'(out_valid),  64'd0);

    // Single requester on the up port
    req_v   = 5'b00100;
    flit[2] = 33'h0_1234_5678;
    cycle(1'b1, 1'b0);
    chk("single_ready", 64'(obs_ready),  64'b00100);
    chk("single_data",  64'(out_data),   64'h0_1234_5678);
    chk("single_last",  64'(last_grant), 64'd2);
    req_v = '0;
    cycle(1'b1, 1'b0);
    chk("single_drain", 64'(out_valid), 64'd0);

    // All five continuously valid: strict cyclic order, no gaps
    cycle(1'b1, 1'b1);
    req_v = '1;
    for (int k = 0; k < 11; k++) begin
      cycle(1'b1, 1'b0);
      chk("rr_seq",   64'(last_grant), 64'(k % 5));
      chk("rr_nogap", 64'(out_valid),  64'd1);
      refill(1'b1);
    end

    // Backpressure for 10 cycles; watchdog trips after the 8th stalled cycle
    snap = out_data;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0);
      chk("bp_ready",  64'(obs_ready), 64'd0);
      chk("bp_stable", 64'(out_data),  64'(snap));
      chk("wd_rise",   64'(stall_err), 64'(i >= 7));
    end
    // Release: drain and next grant on the same edge; error stays sticky
    cycle(1'b1, 1'b0);
    chk("bp_release_ready", 64'(obs_ready), 64'b00010);
    chk("bp_release_valid", 64'(out_valid), 64'd1);
    chk("wd_sticky",        64'(stall_err), 64'd1);
    refill(1'b1);

    // Reach FULL with last_grant=3, then reset for one cycle
    cycle(1'b1, 1'b0); refill(1'b1);
    cycle(1'b1, 1'b0); refill(1'b1);
    chk("pre_rst_last", 64'(last_grant), 64'd3);
    cycle(1'b0, 1'b1);
    chk("mid_rst_ready", 64'(obs_ready),  64'd0);
    chk("mid_rst_valid", 64'(out_valid),  64'd0);
    chk("mid_rst_last",  64'(last_grant), 64'd4);
    chk("mid_rst_err",   64'(stall_err),  64'd0);
    cycle(1'b1, 1'b0);
    chk("post_rst_first", 64'(obs_ready), 64'b00001);
    refill(1'b1);

    // Skip fairness: only requesters 1 and 3, starting from last_grant=1
    cycle(1'b1, 1'b1);
    req_v = 5'b00010;
    cycle(1'b1, 1'b0);
    refill(1'b1);
    req_v = 5'b01010;
    seq[0] = 3; seq[1] = 1; seq[2] = 3;
    for (int j = 0; j < 3; j++) begin
      cycle(1'b1, 1'b0);
      chk("skip_seq",   64'(last_grant),          64'(seq[j]));
      chk("skip_never", 64'(obs_ready & 5'b10101), 64'd0);
      refill(1'b1);
    end

    // Randomized traffic: light then heavy backpressure, occasional reset
    cycle(1'b1, 1'b1);
    for (int c = 0; c < 600; c++) begin
      logic rdy;
      logic rst;
      for (int i = 0; i < N; i++) begin
        logic [N-1:0] t;
        t = req_v >> i;
        if (!t[0] && $urandom_range(0, 1) == 1) begin
          flit[i] = rnd_flit();
          req_v   = req_v | (N'(1) << i);
        end
      end
      rdy = (c < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 79) == 0);
      cycle(rdy, rst);
      refill(1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
